// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and sizing helpers for the SAR search/track controller
package sar_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, TRACK} state_t;
  localparam int FILT_W_DEFAULT = 3;
  function automatic int filt_w(int tf);
    return $clog2(tf) + 1;
  endfunction
  function automatic logic [15:0] midscale(int n);
    return 16'(1) << (n - 1);
  endfunction
endpackage

// File: rtl/sar_track_filter.sv
// sar_track_filter: signed run-length filter emitting one step pulse per TRACK_FILT same-direction comparisons
module sar_track_filter
  import sar_pkg::*;
#(
  parameter int TRACK_FILT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic comp,
  input  logic en,
  input  logic clr,
  output logic step_up,
  output logic step_dn
);
  localparam int FW = filt_w(TRACK_FILT);
  logic signed [FW-1:0] cnt;
  int nxt;
  // next run length: a direction reversal restarts the run at +/-1
  always_comb begin
    nxt = comp ? (cnt < 0 ? 1 : int'(cnt) + 1) : (cnt > 0 ? -1 : int'(cnt) - 1);
    step_up = en && !clr && nxt == TRACK_FILT;
    step_dn = en && !clr && nxt == -TRACK_FILT;
  end
  // run register, emptied on every step and whenever tracking is not active
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!en || clr || step_up || step_dn) cnt <= '0;
    else cnt <= FW'(nxt);
endmodule

// File: rtl/sar_search_track.sv
// sar_search_track: binary-search delay-code controller with filtered +/-1 tracking and relock
module sar_search_track
  import sar_pkg::*;
#(
  parameter int N_BITS      = 10,
  parameter int TRACK_FILT  = 4,
  parameter int AUTO_RELOCK = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      track_en,
  input  logic                      comp,
  output logic [N_BITS-1:0]         code,
  output logic [$clog2(N_BITS)-1:0] bit_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      locked
);
  localparam int IW = $clog2(N_BITS);
  localparam logic [N_BITS-1:0] MID = N_BITS'(midscale(N_BITS));
  localparam logic [IW-1:0] TOP = IW'(N_BITS - 1);
  state_t state, state_n;
  logic [N_BITS-1:0] code_n;
  logic [IW-1:0] idx_n;
  logic busy_n, done_n, locked_n, step_up, step_dn, sat;
  sar_track_filter #(.TRACK_FILT(TRACK_FILT)) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .comp   (comp),
    .en     (state == TRACK),
    .clr    (start || !track_en),
    .step_up(step_up),
    .step_dn(step_dn)
  );
  // next code/handshake; start and relock both restart from midscale
  always_comb begin
    state_n  = state;
    code_n   = code;
    idx_n    = bit_idx;
    busy_n   = busy;
    done_n   = 1'b0;
    locked_n = locked;
    sat      = (step_up && &code) || (step_dn && ~|code);
    if (start || (state == TRACK && track_en && sat && AUTO_RELOCK != 0)) begin
      state_n  = SEARCH;
      code_n   = MID;
      idx_n    = TOP;
      busy_n   = 1'b1;
      locked_n = 1'b0;
    end else if (state == SEARCH) begin
      code_n[bit_idx] = comp;
      if (bit_idx != '0) begin
        code_n[bit_idx-1'b1] = 1'b1;
        idx_n = bit_idx - 1'b1;
      end else begin
        done_n   = 1'b1;
        locked_n = 1'b1;
        busy_n   = 1'b0;
        state_n  = track_en ? TRACK : IDLE;
      end
    end else if (state == TRACK) begin
      if (!track_en) state_n = IDLE;
      else if (sat) begin
        state_n  = IDLE;
        locked_n = 1'b0;
      end else if (step_up) code_n = code + 1'b1;
      else if (step_dn) code_n = code - 1'b1;
    end
  end
  // all registered outputs update on the falling edge
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      code    <= MID;
      bit_idx <= TOP;
      busy    <= 1'b0;
      done    <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state   <= state_n;
      code    <= code_n;
      bit_idx <= idx_n;
      busy    <= busy_n;
      done    <= done_n;
      locked  <= locked_n;
    end
endmodule

// File: tb/tb_sar_search_track.sv
// tb_sar_search_track: directed and random checks of two configurations against a behavioural model
module tb_sar_search_track;
  logic clk = 0, rst_n = 0, start = 0, track_en = 0, comp = 0;
  logic [9:0] code_a;
  logic [3:0] idx_a;
  logic busy_a, done_a, locked_a;
  logic [3:0] code_b;
  logic [1:0] idx_b;
  logic busy_b, done_b, locked_b;
  int n_chk = 0, n_pass = 0, bias = 50;
  int pat[10] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1};
  typedef struct {int mode; int code; int k; int run; bit busy; bit done; bit locked;} mdl_t;
  mdl_t ma, mb;

  sar_search_track #(.N_BITS(10), .TRACK_FILT(4), .AUTO_RELOCK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .track_en(track_en), .comp(comp),
    .code(code_a), .bit_idx(idx_a), .busy(busy_a), .done(done_a), .locked(locked_a));
  sar_search_track #(.N_BITS(4), .TRACK_FILT(2), .AUTO_RELOCK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .track_en(track_en), .comp(comp),
    .code(code_b), .bit_idx(idx_b), .busy(busy_b), .done(done_b), .locked(locked_b));

  always #5 clk = ~clk;

  function automatic mdl_t mreset(int n);
    mdl_t m;
    m.mode = 0; m.code = 1 << (n - 1); m.k = n - 1; m.run = 0;
    m.busy = 0; m.done = 0; m.locked = 0;
    return m;
  endfunction

  // mode 0 idle, 1 searching, 2 tracking; run is the signed same-direction streak
  function automatic mdl_t mstep(mdl_t m, int n, int tf, bit ar, bit st, bit te, bit c);
    int top = (1 << n) - 1;
    m.done = 0;
    if (st) begin
      m.mode = 1; m.code = 1 << (n - 1); m.k = n - 1; m.run = 0; m.busy = 1; m.locked = 0;
      return m;
    end
    if (m.mode == 1) begin
      m.code = c ? (m.code | (1 << m.k)) : (m.code & ~(1 << m.k));
      if (m.k > 0) begin
        m.k--;
        m.code |= 1 << m.k;
      end else begin
        m.done = 1; m.locked = 1; m.busy = 0; m.mode = te ? 2 : 0; m.run = 0;
      end
    end else if (m.mode == 2) begin
      if (!te) begin
        m.mode = 0; m.run = 0;
      end else begin
        m.run = c ? (m.run > 0 ? m.run + 1 : 1) : (m.run < 0 ? m.run - 1 : -1);
        if (m.run == tf || m.run == -tf) begin
          int tgt = m.code + (m.run > 0 ? 1 : -1);
          m.run = 0;
          if (tgt < 0 || tgt > top) begin
            m.locked = 0;
            if (ar) begin
              m.mode = 1; m.code = 1 << (n - 1); m.k = n - 1; m.busy = 1;
            end else m.mode = 0;
          end else m.code = tgt;
        end
      end
    end
    return m;
  endfunction

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_all();
    chk("a.code", code_a, ma.code);
    chk("a.bit_idx", idx_a, ma.k);
    chk("a.busy", busy_a, ma.busy);
    chk("a.done", done_a, ma.done);
    chk("a.locked", locked_a, ma.locked);
    chk("b.code", code_b, mb.code);
    chk("b.bit_idx", idx_b, mb.k);
    chk("b.busy", busy_b, mb.busy);
    chk("b.done", done_b, mb.done);
    chk("b.locked", locked_b, mb.locked);
  endtask

  task automatic cyc(bit st, bit te, bit c);
    start = st; track_en = te; comp = c;
    @(negedge clk);
    ma = mstep(ma, 10, 4, 1, st, te, c);
    mb = mstep(mb, 4, 2, 0, st, te, c);
    @(posedge clk);
    chk_all();
  endtask

  initial begin
    ma = mreset(10);
    mb = mreset(4);
    repeat (2) @(posedge clk);
    chk_all();
    chk("rst.code", code_a, 'h200);
    chk("rst.idx", idx_a, 9);
    rst_n = 1;
    // search pattern then tracking steps
    cyc(1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, pat[i][0]);
    chk("pat.code", code_a, 'h2CB);
    chk("pat.done", done_a, 1);
    chk("pat.locked", locked_a, 1);
    chk("pat.busy", busy_a, 0);
    repeat (4) cyc(0, 1, 1);
    chk("trk.up", code_a, 'h2CC);
    cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 0);
    chk("trk.hold", code_a, 'h2CC);
    repeat (4) cyc(0, 1, 0);
    chk("trk.dn", code_a, 'h2CB);
    // all-ones search, then saturation (relock on a, hold on b)
    cyc(1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 1);
      if (i == 3) chk("b.ones", code_b, 'hF);
    end
    chk("a.ones", code_a, 'h3FF);
    chk("b.sat.code", code_b, 'hF);
    chk("b.sat.locked", locked_b, 0);
    chk("b.sat.busy", busy_b, 0);
    repeat (4) cyc(0, 1, 1);
    chk("a.sat.locked", locked_a, 0);
    chk("a.sat.busy", busy_a, 1);
    chk("a.sat.code", code_a, 'h200);
    // all-zeros search
    cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    chk("a.zeros", code_a, 0);
    // restart mid-search
    cyc(1, 0, 1);
    repeat (4) cyc(0, 0, 1);
    chk("int.idx5", idx_a, 5);
    cyc(1, 0, 1);
    chk("int.code", code_a, 'h200);
    chk("int.idx", idx_a, 9);
    chk("int.done", done_a, 0);
    repeat (10) cyc(0, 0, $urandom_range(0, 1) == 1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) bias = $urandom_range(10, 90);
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 99) < bias);
    end
    // asynchronous reset mid-track
    cyc(1, 1, 1);
    repeat (12) cyc(0, 1, 1);
    #2 rst_n = 0;
    #1;
    ma = mreset(10);
    mb = mreset(4);
    chk_all();
    chk("arst.code", code_a, 'h200);
    chk("arst.locked", locked_a, 0);
    @(posedge clk);
    rst_n = 1;
    cyc(0, 1, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
